// File: rtl/spi_sram_pkg.sv
// Shared constants, state type and frame builder for the serial SRAM sequencer.
package spi_sram_pkg;

  localparam int unsigned FrameBits = 32;
  localparam logic [7:0]  OpRead    = 8'h03;
  localparam logic [7:0]  OpWrite   = 8'h02;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  // Read frames carry a don't-care data byte, driven as zero.
  function automatic logic [FrameBits-1:0] build_frame(input logic       we,
                                                       input logic [15:0] addr,
                                                       input logic [7:0]  wdata);
    return we ? {OpWrite, addr, wdata} : {OpRead, addr, 8'h00};
  endfunction

endpackage

// File: rtl/spi_sram_ctrl_if.sv
// Request/response bus between the bus-side agent and the SRAM sequencer.
interface spi_sram_ctrl_if;

  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, done, rdata
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: ClkDiv HCLK cycles per half-period, idle low.
module spi_sclk_gen #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] CntMax = 8'(ClkDiv - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       half_end;

  // Strobes mark the edge on which sclk_q toggles.
  always_comb begin
    half_end = en_i && (cnt_q == CntMax);
    rise_o   = half_end && !sclk_q;
    fall_o   = half_end && sclk_q;
    cnt_d    = '0;
    sclk_d   = 1'b0;
    if (en_i) begin
      cnt_d  = half_end ? 8'd0 : cnt_q + 8'd1;
      sclk_d = half_end ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_sram_ctrl.sv
// Single-byte read/write sequencer for a 23LC512-class SPI SRAM (mode 0, sequential mode).
module spi_sram_ctrl
  import spi_sram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  spi_sram_ctrl_if.slave        bus_io,
  output logic                  SCLK,
  output logic                  SSn,
  output logic                  MSO,
  input  logic                  MSI
);

  localparam logic [4:0] LastBit = 5'(FrameBits - 1);
  // SSn is already high in the done cycle and the IDLE cycle, so GAP holds CS_GAP-1 cycles
  // (at least one, to keep busy asserted during done).
  localparam logic [3:0] GapLoad = (CS_GAP > 1) ? 4'(CS_GAP - 2) : 4'd0;

  state_e                 state_q, state_d;
  logic [4:0]             bit_q, bit_d;
  logic [3:0]             gap_q, gap_d;
  logic [FrameBits-1:0]   tx_q, tx_d;
  logic [7:0]             rx_q, rx_d;
  logic                   we_q, we_d;
  logic                   ssn_q, ssn_d;
  logic                   done_q, done_d;
  logic [7:0]             rdata_q, rdata_d;

  logic                   sclk_en;
  logic                   sclk_rise;
  logic                   sclk_fall;

  assign sclk_en = (state_q == StShift);

  spi_sclk_gen #(
    .ClkDiv (CLK_DIV)
  ) u_sclk_gen (
    .clk_i  (HCLK),
    .rst_i  (HRESET),
    .en_i   (sclk_en),
    .sclk_o (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    we_d    = we_q;
    ssn_d   = ssn_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.req) begin
          state_d = StShift;
          we_d    = bus_io.we;
          tx_d    = build_frame(bus_io.we, bus_io.addr, bus_io.wdata);
          bit_d   = '0;
          rx_d    = '0;
          ssn_d   = 1'b0;
        end
      end

      StShift: begin
        // Only the data-phase bits (24..31) carry SRAM output.
        if (sclk_rise && (bit_q[4:3] == 2'b11)) begin
          rx_d = {rx_q[6:0], MSI};
        end
        if (sclk_fall) begin
          if (bit_q == LastBit) begin
            state_d = StGap;
            gap_d   = GapLoad;
            ssn_d   = 1'b1;
            done_d  = 1'b1;
            tx_d    = '0;
            bit_d   = '0;
            if (!we_q) begin
              rdata_d = rx_q;
            end
          end else begin
            bit_d = bit_q + 5'd1;
            tx_d  = {tx_q[FrameBits-2:0], 1'b0};
          end
        end
      end

      StGap: begin
        if (gap_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      we_q    <= 1'b0;
      ssn_q   <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      we_q    <= we_d;
      ssn_q   <= ssn_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign SSn          = ssn_q;
  assign MSO          = tx_q[FrameBits-1];
  assign bus_io.busy  = (state_q != StIdle);
  assign bus_io.done  = done_q;
  assign bus_io.rdata = rdata_q;

endmodule

// File: doc/spi_sram_ctrl.md
# spi_sram_ctrl

Single-byte read/write sequencer for the 64 KB serial SRAM (23LC512-class) attached to the SoC's SPI pins. Accepts one request at a time from a bus-side agent, serialises command, 16-bit address and data in SPI mode 0, and returns read data with a one-cycle done pulse. Sits between the AHB-side slave logic and the MSI/MSO/SSn/SCLK pads, owning the SPI pins exclusively.

## Interface

Parameters:
- CLK_DIV, 4: HCLK cycles per SCK half-period; legal range 1..255; 0 is illegal.
- CS_GAP, 2: minimum HCLK cycles SSn stays high between transactions; legal range 1..15.

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- req  in  1  start request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; latched on accept.
- addr  in  16  byte address; latched on accept.
- wdata  in  8  write byte; latched on accept.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read byte; valid from done, held until next read's done.
- SCLK  out  1  SPI clock, idle low.
- SSn  out  1  chip select, active low.
- MSO  out  1  controller-to-SRAM data.
- MSI  in  1  SRAM-to-controller data.

## Operation

- States: IDLE, SHIFT, GAP.
- IDLE: SSn=1, SCLK=0, busy=0. On req=1: latch we/addr/wdata, load 32-bit shift register {opcode, addr, wdata} (opcode 0x02 write, 0x03 read; wdata field = 0x00 for read), move to SHIFT.
- SHIFT: SSn=0; 32 bits MSB first. Each bit = CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high. MSO changes only on the edge that drives SCLK low (or on entry). MSI sampled on the edge that drives SCLK high, shifted into an 8-bit receive register during bits 24..31 only.
- After bit 31's high phase: SSn=1, SCLK=0, done=1 for one cycle, rdata updated if read (unchanged if write); go to GAP.
- GAP: counts CS_GAP cycles with SSn=1, busy=1; then IDLE.
- req while busy is ignored; no queue. Requester must re-present req in IDLE.
- Sequential mode of the SRAM (power-on default) is relied upon; no mode-register write.

## Timing

- Reset values: SSn=1, SCLK=0, MSO=0, busy=0, done=0, rdata=0x00, state IDLE, counters 0.
- Accept edge = T0. SSn falls and MSO=opcode bit7 at T0. busy=1 from T0.
- First SCLK rising at T0+CLK_DIV; 32nd falling (SSn rise) at T0+64·CLK_DIV; done high for that single cycle.
- Next accept no earlier than T0+64·CLK_DIV+CS_GAP.
- CLK_DIV=1: SCK = HCLK/2, done 64 cycles after accept.
- HRESET mid-transaction: next edge forces all reset values; no done pulse; partial rdata discarded; SRAM sees SSn rise and aborts.
- HRESET and req in same cycle: reset wins, request dropped.
- addr 0xFFFF and 0x0000 are ordinary; no wrap logic needed (single byte).

## Structure

- Package spi_sram_pkg: opcode constants (OP_READ=8'h03, OP_WRITE=8'h02), state enum {IDLE, SHIFT, GAP}, frame width constant 32.
- One sub-module spi_sclk_gen: half-period counter producing rise/fall strobes and SCLK; parent holds FSM, 5-bit bit counter, shift and receive registers.

## Test plan

- Write then read: write addr 0x1234 data 0xA5, then read 0x1234 against M23LC512 model -> rdata=0xA5 on done; write leaves rdata unchanged.
- Latency: CLK_DIV=1, CS_GAP=2 -> done exactly 64 cycles after accept, SSn low 64 cycles, 32 SCLK rising edges, next accept possible at +66.
- Boundary addresses: write 0x00 to 0x0000 and 0xFF to 0xFFFF, read both back -> 0x00 and 0xFF; MSO frame matches {0x02,0xFFFF,0xFF} bit-for-bit.
- Busy rejection: pulse req three times during SHIFT and GAP -> exactly one transaction, one done pulse.
- Reset mid-op: assert HRESET at bit 12 of a read -> next cycle SSn=1, SCLK=0, busy=0, no done; following read of a previously written 0x3C returns 0x3C.
- Divider sweep: CLK_DIV=1,4,255 -> SCLK half-period equals CLK_DIV cycles, data correct in all cases.
